// File: rtl/bnn_pkg.sv
// Shared definitions for the sequential binary neural network layer family.
// Holds the controller state encoding and the width/chunk-count helpers that
// every layer variant derives its geometry from.
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EVAL = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Width able to hold a count from 0 up to and including n_in.
  function automatic int cnt_w_f(input int n_in);
    return $clog2(n_in + 1);
  endfunction

  // Number of load-bus chunks carrying the weight vector.
  function automatic int cw_f(input int n_in, input int wchunk);
    return (n_in + wchunk - 1) / wchunk;
  endfunction

  // Number of load-bus chunks carrying the threshold.
  function automatic int ct_f(input int cnt_w, input int wchunk);
    return (cnt_w + wchunk - 1) / wchunk;
  endfunction

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational XNOR-popcount: counts positions where input and weight agree.
// Ports:
//   x     - binary input vector
//   w     - binary weight vector
//   count - number of matching bit positions (0..N_IN)
import bnn_pkg::*;

module bnn_xnor_popcount #(
  parameter int  N_IN  = 8,
  localparam int CNT_W = cnt_w_f(N_IN)
) (
  input  logic [N_IN-1:0]  x,
  input  logic [N_IN-1:0]  w,
  output logic [CNT_W-1:0] count
);

  logic [N_IN-1:0] match_s;

  assign match_s = ~(x ^ w);

  // Sum the agreement bits; CNT_W is sized so the full count never wraps.
  always_comb begin
    count = '0;
    for (int i = 0; i < N_IN; i++) begin
      count = count + CNT_W'(match_s[i]);
    end
  end

endmodule

// File: rtl/bnn_layer_seq.sv
// Reloadable binary neural network layer with one time-shared popcount unit.
// Each neuron k fires when popcount(~(x ^ w[k])) >= thr[k]; one neuron is
// evaluated per cycle. Weights/thresholds arrive LSB-chunk first over a narrow
// load bus and commit per neuron when the record's last chunk is accepted.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   ena                  - global enable, low freezes every register
//   in_valid/in_ready    - input vector handshake, in_data is the vector
//   out_valid/out_ready  - result handshake, out_data bit k = neuron k
//   ld_start             - restart the load pointer at neuron 0
//   ld_valid/ld_ready    - load chunk handshake, ld_data is the chunk
//   ld_done              - one-cycle pulse after the last neuron commits
import bnn_pkg::*;

module bnn_layer_seq #(
  parameter int N_IN       = 8,
  parameter int N_OUT      = 8,
  parameter int WCHUNK     = 4,
  parameter int THRESH_DEF = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  out_data,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [WCHUNK-1:0] ld_data,
  output logic              ld_done
);

  localparam int CNT_W = cnt_w_f(N_IN);
  localparam int CW    = cw_f(N_IN, WCHUNK);
  localparam int CT    = ct_f(CNT_W, WCHUNK);
  localparam int NCH   = CW + CT;
  localparam int CC_W  = idx_w_f(NCH);
  localparam int PTR_W = idx_w_f(N_OUT);

  state_t               state_r, state_nxt_s;
  logic [N_IN-1:0]      w_r   [N_OUT];
  logic [CNT_W-1:0]     thr_r [N_OUT];
  logic [N_IN-1:0]      x_r;
  logic [PTR_W-1:0]     idx_r;
  logic [PTR_W-1:0]     ptr_r;
  logic [CC_W-1:0]      chunk_cnt_r;
  logic [NCH*WCHUNK-1:0] shadow_r;
  logic                 out_valid_r;
  logic [N_OUT-1:0]     out_data_r;
  logic                 ld_done_r;

  logic                 in_ready_s, ld_ready_s, in_acc_s, ld_acc_s;
  logic                 commit_s, commit_last_s;
  logic [CC_W-1:0]      chunk_idx_s;
  logic [PTR_W-1:0]     ptr_idx_s;
  logic [NCH*WCHUNK-1:0] rec_s;
  logic [CNT_W-1:0]     count_s;
  logic                 fire_s;

  bnn_xnor_popcount #(.N_IN(N_IN)) u_popcount (
    .x     (x_r),
    .w     (w_r[idx_r]),
    .count (count_s)
  );

  assign fire_s    = (count_s >= thr_r[idx_r]);
  assign in_ready  = in_ready_s;
  assign ld_ready  = ld_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign ld_done   = ld_done_r;

  // Next state, handshake qualification and load-record assembly.
  always_comb begin
    state_nxt_s   = state_r;
    in_ready_s    = 1'b0;
    ld_ready_s    = 1'b0;
    in_acc_s      = 1'b0;
    ld_acc_s      = 1'b0;
    commit_s      = 1'b0;
    commit_last_s = 1'b0;
    // ld_start makes a same-cycle chunk count as chunk 0 of neuron 0.
    chunk_idx_s   = ld_start ? '0 : chunk_cnt_r;
    ptr_idx_s     = ld_start ? '0 : ptr_r;
    rec_s         = ld_start ? '0 : shadow_r;
    rec_s[int'(chunk_idx_s)*WCHUNK +: WCHUNK] = ld_data;
    if (ena) begin
      case (state_r)
        IDLE: begin
          ld_ready_s = 1'b1;
          in_ready_s = !ld_start && !ld_valid;
          if (ld_start || ld_valid) begin
            state_nxt_s = LOAD;
          end else if (in_valid) begin
            in_acc_s    = 1'b1;
            state_nxt_s = EVAL;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        LOAD: begin
          ld_ready_s = 1'b1;
          // Only leave when nothing is half-loaded; a partial record waits.
          if (!ld_valid && (ld_start || chunk_cnt_r == '0)) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = LOAD;
          end
        end
        EVAL: begin
          if (idx_r == PTR_W'(N_OUT - 1)) begin
            state_nxt_s = HOLD;
          end else begin
            state_nxt_s = EVAL;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = HOLD;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
      ld_acc_s      = ld_valid && ld_ready_s;
      commit_s      = ld_acc_s && (chunk_idx_s == CC_W'(NCH - 1));
      commit_last_s = commit_s && (ptr_idx_s == PTR_W'(N_OUT - 1));
      if (commit_last_s) begin
        state_nxt_s = IDLE;
      end else begin
        state_nxt_s = state_nxt_s;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // All layer state: controller, parameter store, load shadow and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      x_r         <= '0;
      idx_r       <= '0;
      ptr_r       <= '0;
      chunk_cnt_r <= '0;
      shadow_r    <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      ld_done_r   <= 1'b0;
      for (int k = 0; k < N_OUT; k++) begin
        w_r[k]   <= '0;
        thr_r[k] <= CNT_W'(THRESH_DEF);
      end
    end else if (ena) begin
      state_r   <= state_nxt_s;
      ld_done_r <= commit_last_s;
      if (ld_ready_s && ld_start) begin
        ptr_r       <= '0;
        chunk_cnt_r <= '0;
        shadow_r    <= '0;
      end
      if (ld_acc_s) begin
        if (commit_s) begin
          w_r[ptr_idx_s]   <= rec_s[N_IN-1:0];
          thr_r[ptr_idx_s] <= rec_s[CW*WCHUNK +: CNT_W];
          chunk_cnt_r      <= '0;
          shadow_r         <= '0;
          ptr_r            <= commit_last_s ? '0 : ptr_idx_s + PTR_W'(1);
        end else begin
          shadow_r    <= rec_s;
          chunk_cnt_r <= chunk_idx_s + CC_W'(1);
          ptr_r       <= ptr_idx_s;
        end
      end
      if (in_acc_s) begin
        x_r   <= in_data;
        idx_r <= '0;
      end
      if (state_r == EVAL) begin
        out_data_r[idx_r] <= fire_s;
        idx_r             <= idx_r + PTR_W'(1);
        if (idx_r == PTR_W'(N_OUT - 1)) begin
          out_valid_r <= 1'b1;
        end
      end
      if (state_r == HOLD && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bnn_layer_seq.sv
// Self-checking bench for bnn_layer_seq (N_IN=8, N_OUT=8, WCHUNK=4).
// Expected results come from a reference model of the stored weights and
// thresholds, pushed to a queue at input time and popped at result time.
module tb_bnn_layer_seq;

  logic       clk = 1'b0;
  logic       reset, ena, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic       ld_start, ld_valid, ld_ready, ld_done;
  logic [3:0] ld_data;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mw[8];
  logic [3:0] mt[8];
  int         mptr;

  bnn_layer_seq dut (
    .clk(clk), .reset(reset), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_done(ld_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_eval(input logic [7:0] x);
    logic [7:0] r;
    int c;
    r = 8'h00;
    for (int k = 0; k < 8; k++) begin
      c = $countones(~(x ^ mw[k]));
      r[k] = (c >= int'(mt[k]));
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      mw[k] = 8'h00;
      mt[k] = 4'd7;
    end
    mptr = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Send one full neuron record (3 chunks) back to back.
  task automatic send_record(input logic [7:0] w, input logic [3:0] t, input logic start);
    logic [3:0] ch[3];
    ch[0] = w[3:0];
    ch[1] = w[7:4];
    ch[2] = t;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_start = start && (i == 0);
      ld_data  = ch[i];
      #1;
      n_vec++;
      if (ld_ready !== 1'b1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL load_ready chunk %0d: ld_ready=%b in_ready=%b, want 1/0", i, ld_ready, in_ready);
      end
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_start = 1'b0;
    if (start) mptr = 0;
    mw[mptr] = w;
    mt[mptr] = t;
    n_vec++;
    if (ld_done !== (mptr == 7)) begin
      n_err++;
      $display("FAIL ld_done after neuron %0d: got %b want %b", mptr, ld_done, (mptr == 7));
    end
    mptr = (mptr + 1) % 8;
  endtask

  // Pop and compare a held result, then release it downstream.
  task automatic collect();
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard_empty: got result %h with nothing expected", out_data);
      return;
    end
    e = exp_q.pop_front();
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== e) begin
      n_err++;
      $display("FAIL result: out_valid=%b out_data=%h want 1/%h", out_valid, out_data, e);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL out_valid_drop: got %b want 0", out_valid);
    end
  endtask

  task automatic run_vec(input logic [7:0] x);
    int guard, lat;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL in_ready_wait: got %b want 1", in_ready);
    end
    in_data  = x;
    in_valid = 1'b1;
    exp_q.push_back(model_eval(x));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_vec++;
    if (lat != 9) begin
      n_err++;
      $display("FAIL latency x=%h: got %0d cycles want 9", x, lat);
    end
    @(negedge clk);
    collect();
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || ld_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b data=%h done=%b want 0/00/0", out_valid, out_data, ld_done);
    end
    n_vec++;
    if (in_ready !== 1'b1 || ld_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: in_ready=%b ld_ready=%b want 1/1", in_ready, ld_ready);
    end
  endtask

  task automatic test_default_eval();
    run_vec(8'h00);
    run_vec(8'h03);
    run_vec(8'h01);
  endtask

  task automatic test_load_one();
    send_record(8'hE0, 4'd7, 1'b0);
    run_vec(8'hE0);
    run_vec(8'hC0);
  endtask

  task automatic test_backpressure();
    logic [7:0] e;
    int guard;
    while (in_ready !== 1'b1) @(negedge clk);
    in_data  = 8'hE1;
    in_valid = 1'b1;
    e = model_eval(8'hE1);
    guard = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold_stable %0d: valid=%b data=%h in_ready=%b want 1/%h/0", i, out_valid, out_data, in_ready, e);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_data   = 8'hFF;
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL hold_release: valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    exp_q.push_back(model_eval(8'hFF));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    collect();
  endtask

  task automatic test_load_all();
    for (int k = 0; k < 8; k++) begin
      send_record(8'($urandom_range(0, 255)), 4'($urandom_range(0, 9)), k == 0);
    end
    // 25th chunk starts a fresh neuron-0 record; finish it after a gap.
    ld_valid = 1'b1;
    ld_data  = 4'h5;
    @(negedge clk);
    ld_valid = 1'b0;
    n_vec++;
    if (ld_done !== 1'b0) begin
      n_err++;
      $display("FAIL ld_done_pulse: got %b want 0", ld_done);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL partial_stays_load: in_ready=%b want 0", in_ready);
    end
    ld_valid = 1'b1;
    ld_data  = 4'hA;
    @(negedge clk);
    ld_data  = 4'h3;
    @(negedge clk);
    ld_valid = 1'b0;
    mw[0] = 8'hA5;
    mt[0] = 4'd3;
    mptr  = 1;
    run_vec(8'hA5);
    for (int i = 0; i < 3; i++) run_vec(8'($urandom_range(0, 255)));
  endtask

  task automatic test_abort();
    do_reset();
    ld_valid = 1'b1;
    ld_data  = 4'hF;
    repeat (2) @(negedge clk);
    ld_valid = 1'b0;
    do_reset();
    run_vec(8'h00);
    ld_valid = 1'b1;
    ld_data  = 4'hF;
    repeat (2) @(negedge clk);
    ld_valid = 1'b0;
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    run_vec(8'h00);
    run_vec(8'hFF);
  endtask

  task automatic test_priority_thresholds();
    while (in_ready !== 1'b1) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h55;
    send_record(8'h00, 4'd7, 1'b1);
    in_valid = 1'b0;
    send_record(8'h00, 4'd7, 1'b0);
    send_record(8'h00, 4'd7, 1'b0);
    send_record(8'h00, 4'd0, 1'b0);
    send_record(8'h00, 4'd9, 1'b0);
    repeat (2) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL load_priority: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    run_vec(8'h00);
    run_vec(8'hFF);
    run_vec(8'h0F);
  endtask

  task automatic test_ena();
    int guard;
    while (in_ready !== 1'b1) @(negedge clk);
    ena      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    ld_valid = 1'b1;
    ld_data  = 4'hF;
    #1;
    n_vec++;
    if (in_ready !== 1'b0 || ld_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ena_low_ready: in_ready=%b ld_ready=%b want 0/0", in_ready, ld_ready);
    end
    @(negedge clk);
    ld_valid = 1'b0;
    ena      = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ena_frozen_idle: in_ready=%b want 1", in_ready);
    end
    exp_q.push_back(model_eval(8'h3C));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ena = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ena_freeze_eval: out_valid=%b want 0", out_valid);
    end
    ena = 1'b1;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    ena       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    ena       = 1'b1;
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL ena_freeze_hold: out_valid=%b want 1", out_valid);
    end
    collect();
  endtask

  initial begin
    reset = 1'b1; ena = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    out_ready = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 4'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    test_reset();
    test_default_eval();
    test_load_one();
    test_backpressure();
    test_load_all();
    test_abort();
    test_priority_thresholds();
    test_ena();
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard_leftover: %0d results never produced", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
